// File: rtl/relm_i2c_target.sv
// I2C target exposing a 2**WRA byte register file; ReLM software shares the same
// registers through a {strobe, index, data} push port and a combinational pop port.
module relm_i2c_target #(
  parameter int         WD       = 32,
  parameter int         WRA      = 4,
  parameter logic [6:0] I2C_ADDR = 7'h42
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe_out,
  input  logic [WD:0] push_d,
  input  logic [WD:0] pop_d,
  output logic [WD:0] pop_q
);

  localparam int NREG = 2 ** WRA;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t           state, state_n;
  logic [2:0]       scl_s, sda_s;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shreg, shreg_n, shifted;
  logic [WRA-1:0]   ptr, ptr_n, ptr_inc;
  logic             rw, rw_n, oe_n, i2c_we;
  logic             start_ev, stop_ev, rise, fall, sda_bit;
  logic [7:0]       regs [NREG];
  logic [NREG-1:0]  dirty;

  logic [WRA-1:0]   push_idx, pop_idx;
  logic             unused_bits;

  assign push_idx    = push_d[8 +: WRA];
  assign pop_idx     = pop_d[8 +: WRA];
  assign unused_bits = ^{push_d[WD-1:8+WRA], pop_d[WD-1:8+WRA], pop_d[7:0]};

  // [0] and [1] form the synchronizer; [2] is the previous value for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s <= 3'b111;
      sda_s <= 3'b111;
    end else begin
      scl_s <= {scl_s[1:0], scl_in};
      sda_s <= {sda_s[1:0], sda_in};
    end
  end

  assign sda_bit  = sda_s[1];
  assign rise     = scl_s[1] & ~scl_s[2];
  assign fall     = ~scl_s[1] & scl_s[2];
  assign start_ev = scl_s[1] & scl_s[2] & sda_s[2] & ~sda_s[1];
  assign stop_ev  = scl_s[1] & scl_s[2] & ~sda_s[2] & sda_s[1];
  assign shifted  = {shreg[6:0], sda_bit};
  assign ptr_inc  = ptr + WRA'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      ptr        <= '0;
      rw         <= 1'b0;
      sda_oe_out <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      ptr        <= ptr_n;
      rw         <= rw_n;
      sda_oe_out <= oe_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    rw_n      = rw;
    oe_n      = sda_oe_out;
    i2c_we    = 1'b0;
    if (stop_ev) begin
      state_n = IDLE;
      oe_n    = 1'b0;
    end else if (start_ev) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      oe_n      = 1'b0;
    end else begin
      case (state)
        ADDR, REG, WDATA: begin
          if (rise) begin
            shreg_n   = shifted;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == ADDR) begin
                if (shifted[7:1] == I2C_ADDR) begin
                  state_n = ADDR_ACK;
                  rw_n    = shifted[0];
                end else begin
                  state_n = IGNORE;
                end
              end else if (state == REG) begin
                ptr_n   = shifted[WRA-1:0];
                state_n = REG_ACK;
              end else begin
                i2c_we  = 1'b1;
                ptr_n   = ptr_inc;
                state_n = WDATA_ACK;
              end
            end
          end
        end
        // First fall after the byte pulls SDA low, the second ends the ACK slot.
        ADDR_ACK, REG_ACK, WDATA_ACK: begin
          if (fall) begin
            if (!sda_oe_out) begin
              oe_n = 1'b1;
            end else if (state == ADDR_ACK && rw) begin
              shreg_n = regs[ptr];
              oe_n    = ~regs[ptr][7];
              state_n = RDATA;
            end else begin
              oe_n    = 1'b0;
              state_n = (state == ADDR_ACK) ? REG : WDATA;
            end
          end
        end
        RDATA: begin
          if (fall) oe_n = ~shreg[7];
          if (rise) begin
            shreg_n   = {shreg[6:0], 1'b0};
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_n = RDATA_ACK;
          end
        end
        RDATA_ACK: begin
          if (fall) oe_n = 1'b0;
          if (rise) begin
            if (!sda_bit) begin
              ptr_n   = ptr_inc;
              shreg_n = regs[ptr_inc];
              state_n = RDATA;
            end else begin
              state_n = IGNORE;
            end
          end
        end
        IGNORE:  oe_n = 1'b0;
        default: ;
      endcase
    end
  end

  // I2C accesses are ordered after host accesses so the bus write and dirty-set win collisions.
  // NOTE: the register file is reset explicitly because software may read it before any write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      dirty <= '0;
    end else begin
      if (push_d[WD]) regs[push_idx] <= push_d[7:0];
      if (i2c_we)     regs[ptr]      <= shifted;
      if (pop_d[WD])  dirty[pop_idx] <= 1'b0;
      if (i2c_we)     dirty[ptr]     <= 1'b1;
    end
  end

  always_comb begin
    pop_q      = '0;
    pop_q[7:0] = regs[pop_idx];
    pop_q[8]   = dirty[pop_idx];
    pop_q[9]   = (state != IDLE);
  end

endmodule

// File: tb/tb_relm_i2c_target.sv
// Bench for relm_i2c_target: a bit-level I2C controller model plus host-port register checks.
module tb_relm_i2c_target;

  localparam int WD   = 32;
  localparam int WRA  = 4;
  localparam int HALF = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          scl_pin = 1'b1;
  logic          sda_ctrl = 1'b1;
  logic          sda_in;
  logic          sda_oe_out;
  logic [WD:0]   push_d = '0;
  logic [WD:0]   pop_d = '0;
  logic [WD:0]   pop_q;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  logic mon_en = 1'b0;
  logic oe_seen = 1'b0;
  int   hi_changes = 0;

  assign sda_in = sda_ctrl & ~sda_oe_out;

  always #5 clk = ~clk;

  relm_i2c_target #(.WD(WD), .WRA(WRA), .I2C_ADDR(7'h42)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_pin),
    .sda_in    (sda_in),
    .sda_oe_out(sda_oe_out),
    .push_d    (push_d),
    .pop_d     (pop_d),
    .pop_q     (pop_q)
  );

  always @(posedge clk) if (mon_en && sda_oe_out) oe_seen <= 1'b1;
  always @(sda_oe_out) if (!rst && scl_pin) hi_changes <= hi_changes + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         phase;
    int         idx;
    logic [9:0] exp;   // {busy, dirty, data}
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [WD:0] mk(input logic stb, input int idx, input logic [7:0] data);
    logic [WD:0] v;
    v           = '0;
    v[WD]       = stb;
    v[8 +: WRA] = WRA'(idx);
    v[7:0]      = data;
    return v;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_push(input int idx, input logic [7:0] data);
    @(negedge clk);
    push_d = mk(1'b1, idx, data);
    @(negedge clk);
    push_d = '0;
  endtask

  task automatic host_pop(input int idx);
    @(negedge clk);
    pop_d = mk(1'b1, idx, 8'h00);
    @(negedge clk);
    pop_d = '0;
  endtask

  task automatic check_phase(input int p);
    foreach (vecs[i]) begin
      if (vecs[i].phase == p) begin
        pop_d = mk(1'b0, vecs[i].idx, 8'h00);
        #1;
        check($sformatf("p%0d_reg%0d", p, vecs[i].idx), {22'd0, pop_q[9:0]}, {22'd0, vecs[i].exp});
        pop_d = '0;
      end
    end
  endtask

  // One SCL period; the data bit is set while SCL is low and SDA is sampled mid-high.
  // With collide set, host push and pop of index 2 land on the clk that sees the synced rise.
  task automatic clk_bit(input logic b, input bit collide, output logic s);
    sda_ctrl = b;
    wait_clk(HALF);
    scl_pin = 1'b1;
    if (collide) begin
      wait_clk(2);
      push_d = mk(1'b1, 2, 8'h99);
      pop_d  = mk(1'b1, 2, 8'h00);
      wait_clk(1);
      push_d = '0;
      pop_d  = '0;
      wait_clk(HALF / 2 - 3);
    end else begin
      wait_clk(HALF / 2);
    end
    s = sda_in;
    wait_clk(HALF / 2);
    scl_pin = 1'b0;
    wait_clk(2);
  endtask

  task automatic bus_start();
    sda_ctrl = 1'b1;
    wait_clk(HALF);
    scl_pin = 1'b1;
    wait_clk(HALF);
    sda_ctrl = 1'b0;
    wait_clk(HALF);
    scl_pin = 1'b0;
    wait_clk(2);
  endtask

  task automatic bus_stop();
    sda_ctrl = 1'b0;
    wait_clk(HALF);
    scl_pin = 1'b1;
    wait_clk(HALF);
    sda_ctrl = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic write_byte(input string name, input logic [7:0] b, input logic exp_ack,
                            input bit collide = 1'b0);
    logic s;
    exp_q.push_back(int'(exp_ack));
    for (int i = 7; i >= 0; i--) clk_bit(b[i], collide && (i == 0), s);
    clk_bit(1'b1, 1'b0, s);
    check(name, {31'd0, ~s}, exp_q.pop_front());
  endtask

  task automatic read_byte(input string name, input logic [7:0] exp_b, input logic nack);
    logic       s;
    logic [7:0] b;
    b = '0;
    exp_q.push_back(int'(exp_b));
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, 1'b0, s);
      b = {b[6:0], s};
    end
    clk_bit(nack, 1'b0, s);
    check(name, {24'd0, b}, exp_q.pop_front());
  endtask

  initial begin
    logic s;

    vecs = '{
      '{0, 0, 10'h000}, '{0, 15, 10'h000},
      '{1, 3, 10'h1A5}, '{1, 4, 10'h15A}, '{1, 5, 10'h000},
      '{11, 3, 10'h0A5}, '{11, 4, 10'h15A},
      '{2, 15, 10'h011}, '{2, 0, 10'h022},
      '{3, 0, 10'h022}, '{3, 15, 10'h011}, '{3, 3, 10'h0A5}, '{3, 4, 10'h15A},
      '{4, 2, 10'h177},
      '{5, 2, 10'h000}, '{5, 4, 10'h000}, '{5, 15, 10'h000},
      '{6, 7, 10'h13C}, '{6, 8, 10'h05D}, '{6, 9, 10'h000}
    };

    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    check("reset_oe", {31'd0, sda_oe_out}, 0);
    check("popq_upper_zero", {9'd0, pop_q[WD:10]}, 0);
    check_phase(0);

    // Write with auto-increment.
    bus_start();
    write_byte("t1_addr_ack", 8'h84, 1'b1);
    write_byte("t1_reg_ack", 8'h03, 1'b1);
    write_byte("t1_d0_ack", 8'hA5, 1'b1);
    write_byte("t1_d1_ack", 8'h5A, 1'b1);
    bus_stop();
    check_phase(1);
    host_pop(3);
    check_phase(11);

    // Read with repeated START and pointer wrap 15 -> 0.
    host_push(15, 8'h11);
    host_push(0, 8'h22);
    bus_start();
    write_byte("t2_addr_ack", 8'h84, 1'b1);
    write_byte("t2_reg_ack", 8'h0F, 1'b1);
    bus_start();
    write_byte("t2_raddr_ack", 8'h85, 1'b1);
    read_byte("t2_rd0", 8'h11, 1'b0);
    read_byte("t2_rd1", 8'h22, 1'b1);
    bus_stop();
    check("t2_oe_idle", {31'd0, sda_oe_out}, 0);
    check_phase(2);

    // Address mismatch: target never touches SDA.
    oe_seen = 1'b0;
    mon_en  = 1'b1;
    bus_start();
    write_byte("t3_addr_nack", 8'h86, 1'b0);
    write_byte("t3_b1_nack", 8'h00, 1'b0);
    write_byte("t3_b2_nack", 8'hFF, 1'b0);
    bus_stop();
    mon_en = 1'b0;
    wait_clk(1);
    check("t3_oe_never", {31'd0, oe_seen}, 0);
    check_phase(3);

    // Same-clk I2C write, host push and pop strobe on index 2.
    bus_start();
    write_byte("t4_addr_ack", 8'h84, 1'b1);
    write_byte("t4_reg_ack", 8'h02, 1'b1);
    write_byte("t4_data_ack", 8'h77, 1'b1, 1'b1);
    bus_stop();
    check_phase(4);

    // Reset in the middle of a read while the target drives SDA low.
    bus_start();
    write_byte("t5_addr_ack", 8'h84, 1'b1);
    write_byte("t5_reg_ack", 8'h06, 1'b1);
    bus_start();
    write_byte("t5_raddr_ack", 8'h85, 1'b1);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, 1'b0, s);
    wait_clk(2);
    check("t5_oe_before_rst", {31'd0, sda_oe_out}, 1);
    #2 rst = 1'b1;
    #1 check("t5_oe_async_rst", {31'd0, sda_oe_out}, 0);
    scl_pin  = 1'b1;
    sda_ctrl = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(4);
    check_phase(5);
    bus_start();
    write_byte("t5_post_addr_ack", 8'h84, 1'b1);
    bus_stop();

    // STOP after four bits of a data byte: no write, pointer kept.
    host_push(8, 8'h5D);
    bus_start();
    write_byte("t6_addr_ack", 8'h84, 1'b1);
    write_byte("t6_reg_ack", 8'h07, 1'b1);
    write_byte("t6_d0_ack", 8'h3C, 1'b1);
    clk_bit(1'b1, 1'b0, s);
    clk_bit(1'b1, 1'b0, s);
    clk_bit(1'b0, 1'b0, s);
    clk_bit(1'b0, 1'b0, s);
    bus_stop();
    #1 check("t6_busy_after_stop", {31'd0, pop_q[9]}, 0);
    bus_start();
    write_byte("t6_raddr_ack", 8'h85, 1'b1);
    read_byte("t6_rd_ptr_kept", 8'h5D, 1'b1);
    bus_stop();
    check_phase(6);

    check("oe_changes_while_scl_high", hi_changes, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
